led_p2s_ctrl: RTL and testbench

//   Sequencer for the LED/segment serial chain (8-bit + 9-bit shift registers, 17 bits).

---
 rtl/led_p2s_ctrl_pkg.sv | 20 ++
 rtl/p2s_shreg.sv | 28 ++
 rtl/led_p2s_ctrl.sv | 157 +++++++++++++++
 tb/tb_led_p2s_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_p2s_ctrl_pkg.sv
// Shared types and sizing helpers for the LED/segment serial chain sequencer.
// Frame defaults match the 8-bit + 9-bit chained shift registers.
package led_p2s_ctrl_pkg;

   localparam int DATA_W_DEF    = 17;
   localparam int DIV_DEF       = 4;
   localparam int LATCH_CYC_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   // Width of a counter that runs 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/p2s_shreg.sv
// Parallel-load, left-shifting frame register; MSB drives the serial line.
// Shifts in zeros, so the line idles low once a frame has fully left.
module p2s_shreg #(
   parameter int DATA_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] d,
   output logic              msb
);

   logic [DATA_W-1:0] q;

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (shift_en) begin
         q <= {q[DATA_W-2:0], 1'b0};
      end
   end

   assign msb = q[DATA_W-1];

endmodule

// File: rtl/led_p2s_ctrl.sv
// Frame sequencer: snapshots a word, clocks it out MSB-first, then latches it.
// One request can be queued while busy; the newest queued word wins.
module led_p2s_ctrl
   import led_p2s_ctrl_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int DIV       = DIV_DEF,
   parameter int LATCH_CYC = LATCH_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] par_in,
   output logic              s_clk,
   output logic              s_data,
   output logic              s_latch,
   output logic              busy,
   output logic              done
);

   localparam int PH_W  = cnt_w(DIV);
   localparam int BIT_W = cnt_w(DATA_W);
   localparam int LAT_W = cnt_w(LATCH_CYC);

   state_t            state;
   logic [PH_W-1:0]   phase;
   logic [BIT_W-1:0]  bitc;
   logic [LAT_W-1:0]  lcnt;
   logic              pending;
   logic [DATA_W-1:0] pend_data;

   logic              ph_last;
   logic              bit_last;
   logic              lat_last;
   logic              load;
   logic              shift_en;
   logic              take_pend;
   logic              queue_req;
   logic [DATA_W-1:0] load_data;

   assign ph_last  = (phase == PH_W'(DIV - 1));
   assign bit_last = (bitc == BIT_W'(DATA_W - 1));
   assign lat_last = (lcnt == LAT_W'(LATCH_CYC - 1));

   // Only an idle controller with nothing queued launches straight from par_in.
   assign queue_req = start && !(state == ST_IDLE && !pending);

   always_comb begin
      load      = 1'b0;
      shift_en  = 1'b0;
      take_pend = 1'b0;
      load_data = par_in;
      unique case (state)
         ST_IDLE: begin
            if (pending) begin
               load      = 1'b1;
               take_pend = 1'b1;
               load_data = pend_data;
            end else if (start) begin
               load = 1'b1;
            end
         end
         ST_SHIFT: shift_en = s_clk && ph_last;
         ST_LATCH: begin
            if (lat_last && pending) begin
               load      = 1'b1;
               take_pend = 1'b1;
               load_data = pend_data;
            end
         end
         default: ;
      endcase
   end

   p2s_shreg #(
      .DATA_W(DATA_W)
   ) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift_en(shift_en),
      .d       (load_data),
      .msb     (s_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         phase     <= '0;
         bitc      <= '0;
         lcnt      <= '0;
         pending   <= 1'b0;
         pend_data <= '0;
         s_clk     <= 1'b0;
         s_latch   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;

         if (queue_req) begin
            pending   <= 1'b1;
            pend_data <= par_in;
         end else if (take_pend) begin
            pending <= 1'b0;
         end

         unique case (state)
            ST_IDLE: begin
               if (load) begin
                  state <= ST_SHIFT;
                  busy  <= 1'b1;
                  phase <= '0;
                  bitc  <= '0;
                  s_clk <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (ph_last) begin
                  phase <= '0;
                  s_clk <= ~s_clk;
                  if (s_clk) begin
                     if (bit_last) begin
                        state   <= ST_LATCH;
                        s_latch <= 1'b1;
                        lcnt    <= '0;
                     end else begin
                        bitc <= bitc + 1'b1;
                     end
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_LATCH: begin
               if (lat_last) begin
                  s_latch <= 1'b0;
                  done    <= 1'b1;
                  lcnt    <= '0;
                  if (pending) begin
                     state <= ST_SHIFT;
                     phase <= '0;
                     bitc  <= '0;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  lcnt <= lcnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_p2s_ctrl.sv
// Randomised bench for led_p2s_ctrl: default build plus a DIV=1/LATCH_CYC=1 build.
// Expected frames, latencies and strobe lengths come from a frame-level model.
module tb_led_p2s_ctrl;

   localparam int W      = 17;
   localparam int LAT_A  = W * 2 * 4 + 2;
   localparam int LAT_B  = W * 2 * 1 + 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] par_in = '0;
   logic         s_clk, s_data, s_latch, busy, done;
   logic         start_b = 1'b0;
   logic [W-1:0] par_b = '0;
   logic         s_clk_b, s_data_b, s_latch_b, busy_b, done_b;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   led_p2s_ctrl dut_a (
      .clk(clk), .rst(rst), .start(start), .par_in(par_in),
      .s_clk(s_clk), .s_data(s_data), .s_latch(s_latch),
      .busy(busy), .done(done)
   );

   led_p2s_ctrl #(.DATA_W(W), .DIV(1), .LATCH_CYC(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .par_in(par_b),
      .s_clk(s_clk_b), .s_data(s_data_b), .s_latch(s_latch_b),
      .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame-level observer for the default build.
   logic mon_bits[$];
   int   done_q[$];
   int   lat_cnt = 0, busy_fall = 0, viol = 0, tog = 0, busy_hi = 0;
   logic pclk = 1'b0, pbusy = 1'b0, pdat = 1'b0;

   always @(negedge clk) begin
      if (s_clk && !pclk) mon_bits.push_back(s_data);
      if (s_clk && pclk && s_data !== pdat) viol++;
      if (s_latch && s_data) viol++;
      if (s_clk !== pclk) tog++;
      if (s_latch) lat_cnt++;
      if (busy) busy_hi++;
      if (done) done_q.push_back(cyc);
      if (pbusy && !busy) busy_fall++;
      pclk = s_clk; pbusy = busy; pdat = s_data;
   end

   function automatic logic [W-1:0] word_at(input int base);
      logic [W-1:0] r = '0;
      for (int i = 0; i < W; i++)
         if (base + i < mon_bits.size()) r = {r[W-2:0], mon_bits[base+i]};
      return r;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      mon_bits.delete(); done_q.delete();
      lat_cnt = 0; busy_fall = 0; viol = 0; tog = 0; busy_hi = 0;
   endtask

   task automatic fire(input logic [W-1:0] w, output int s);
      start = 1'b1; par_in = w; s = cyc + 1;
      step(1);
      start = 1'b0; par_in = W'($urandom);
   endtask

   task automatic wait_done(input int n, input int bound);
      int k = 0;
      while (done_q.size() < n && k < bound) begin step(1); k++; end
      nvec++;
      if (done_q.size() < n) begin
         nerr++;
         $display("FAIL done_timeout: got %0d dones, need %0d", done_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; step(3);
      @(negedge clk);
      nvec++;
      if ({s_clk, s_data, s_latch, busy, done} !== 5'b0) begin
         nerr++; $display("FAIL reset_a: got %b want 00000",
                          {s_clk, s_data, s_latch, busy, done});
      end
      nvec++;
      if ({s_clk_b, s_data_b, s_latch_b, busy_b, done_b} !== 5'b0) begin
         nerr++; $display("FAIL reset_b: got %b want 00000",
                          {s_clk_b, s_data_b, s_latch_b, busy_b, done_b});
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_idle();
      clear_mon(); step(1000);
      nvec++;
      if (tog + lat_cnt + busy_hi + done_q.size() != 0) begin
         nerr++; $display("FAIL idle: tog=%0d latch=%0d busy=%0d done=%0d want all 0",
                          tog, lat_cnt, busy_hi, done_q.size());
      end
   endtask

   task automatic test_single(input logic [W-1:0] w);
      int s;
      clear_mon(); fire(w, s); wait_done(1, LAT_A + 20); step(4);
      nvec++;
      if (done_q.size() == 0 || done_q[0] - s != LAT_A) begin
         nerr++; $display("FAIL single_latency: got %0d want %0d",
                          done_q.size() ? done_q[0] - s : -1, LAT_A);
      end
      nvec++;
      if (mon_bits.size() != W || word_at(0) !== w) begin
         nerr++; $display("FAIL single_word: got %h (%0d bits) want %h (%0d bits)",
                          word_at(0), mon_bits.size(), w, W);
      end
      nvec++;
      if (lat_cnt != 2 || busy_fall != 1 || busy || viol != 0) begin
         nerr++; $display("FAIL single_strobe: latch=%0d fall=%0d busy=%b viol=%0d want 2 1 0 0",
                          lat_cnt, busy_fall, busy, viol);
      end
   endtask

   task automatic test_pending(input logic [W-1:0] w1, input logic [W-1:0] w2,
                               input int dly);
      int s1, s2;
      clear_mon(); fire(w1, s1); step(dly); fire(w2, s2);
      wait_done(2, 2 * LAT_A + 20); step(4);
      nvec++;
      if (done_q.size() < 2 || done_q[1] - done_q[0] != LAT_A || done_q[0] - s1 != LAT_A) begin
         nerr++; $display("FAIL pending_timing: got %0d / %0d want %0d / %0d",
                          done_q.size() ? done_q[0] - s1 : -1,
                          done_q.size() > 1 ? done_q[1] - done_q[0] : -1, LAT_A, LAT_A);
      end
      nvec++;
      if (mon_bits.size() != 2 * W || word_at(0) !== w1 || word_at(W) !== w2) begin
         nerr++; $display("FAIL pending_words: got %h %h (%0d bits) want %h %h",
                          word_at(0), word_at(W), mon_bits.size(), w1, w2);
      end
      nvec++;
      if (busy_fall != 1 || lat_cnt != 4) begin
         nerr++; $display("FAIL pending_busy: fall=%0d latch=%0d want 1 4", busy_fall, lat_cnt);
      end
   endtask

   task automatic test_latest_wins(input logic [W-1:0] wa, input logic [W-1:0] wb);
      int s1, sx;
      logic [W-1:0] w1 = W'($urandom);
      clear_mon(); fire(w1, s1);
      step($urandom_range(0, 50)); fire(wa, sx);
      step($urandom_range(0, 50)); fire(wb, sx);
      wait_done(2, 2 * LAT_A + 20); step(300);
      nvec++;
      if (done_q.size() != 2 || mon_bits.size() != 2 * W) begin
         nerr++; $display("FAIL latest_count: got %0d frames %0d bits want 2 %0d",
                          done_q.size(), mon_bits.size(), 2 * W);
      end
      nvec++;
      if (word_at(0) !== w1 || word_at(W) !== wb) begin
         nerr++; $display("FAIL latest_word: got %h %h want %h %h",
                          word_at(0), word_at(W), w1, wb);
      end
   endtask

   task automatic test_exit_edge();
      int s1, s2;
      logic [W-1:0] w1 = W'($urandom);
      logic [W-1:0] w2 = W'($urandom);
      clear_mon(); fire(w1, s1); step(LAT_A - 1); fire(w2, s2);
      wait_done(2, 2 * LAT_A + 20); step(200);
      nvec++;
      if (done_q.size() != 2 || word_at(0) !== w1 || word_at(W) !== w2) begin
         nerr++; $display("FAIL exit_edge: got %0d frames %h %h want 2 %h %h",
                          done_q.size(), word_at(0), word_at(W), w1, w2);
      end
   endtask

   task automatic test_reset_mid();
      int s, k;
      clear_mon(); fire(W'($urandom), s); step(3); fire(W'($urandom), s);
      k = 0;
      while (mon_bits.size() < 8 && k < 400) begin step(1); k++; end
      rst = 1'b1; step(1); rst = 1'b0;
      nvec++;
      if ({s_clk, s_data, s_latch, busy, done} !== 5'b0) begin
         nerr++; $display("FAIL midreset_out: got %b want 00000",
                          {s_clk, s_data, s_latch, busy, done});
      end
      clear_mon(); step(400);
      nvec++;
      if (done_q.size() + lat_cnt + mon_bits.size() + busy_hi != 0) begin
         nerr++; $display("FAIL midreset_quiet: done=%0d latch=%0d bits=%0d busy=%0d want 0",
                          done_q.size(), lat_cnt, mon_bits.size(), busy_hi);
      end
      test_single(W'($urandom));
   endtask

   task automatic test_div1(input logic [W-1:0] w);
      int s, rises = 0, togs = 0, lat = 0, dn = -1;
      logic pc = 1'b0;
      logic [W-1:0] got = '0;
      start_b = 1'b1; par_b = w; s = cyc + 1;
      step(1); start_b = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (s_clk_b !== pc) togs++;
         if (s_clk_b && !pc) begin rises++; got = {got[W-2:0], s_data_b}; end
         if (s_latch_b) lat++;
         if (done_b && dn < 0) dn = cyc - s;
         pc = s_clk_b;
      end
      step(1);
      nvec++;
      if (dn != LAT_B || lat != 1) begin
         nerr++; $display("FAIL div1_timing: latency %0d latch %0d want %0d 1", dn, lat, LAT_B);
      end
      nvec++;
      if (rises != W || togs != 2 * W || got !== w) begin
         nerr++; $display("FAIL div1_shift: rises %0d toggles %0d word %h want %0d %0d %h",
                          rises, togs, got, W, 2 * W, w);
      end
   endtask

   task automatic test_start_rst_same();
      int seen = 0;
      rst = 1'b1; start_b = 1'b1; par_b = W'($urandom);
      step(1); rst = 1'b0; start_b = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (busy_b || s_clk_b || done_b || s_latch_b) seen++;
      end
      step(1);
      nvec++;
      if (seen != 0) begin
         nerr++; $display("FAIL start_rst_same: active cycles %0d want 0", seen);
      end
   endtask

   initial begin
      step(1);
      test_reset();
      test_idle();
      test_single(17'h1_A5C3);
      repeat (3) test_single(W'($urandom));
      test_pending(W'($urandom), 17'h0_00FF, $urandom_range(0, 125));
      repeat (2) test_pending(W'($urandom), W'($urandom), $urandom_range(0, 125));
      test_latest_wins(17'h1_0001, 17'h0_8000);
      test_latest_wins(W'($urandom), W'($urandom));
      test_exit_edge();
      test_reset_mid();
      test_div1(17'h1_FFFF);
      test_div1(W'($urandom));
      test_start_rst_same();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
